// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and the data stage (MEM).
// Define ARB_RR_EN for round-robin tie-breaking; by default MEM always wins ties.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic [15:0] rdata,
  output logic        if_done,
  output logic        mem_done,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } stateT;

  // WAIT spans LAT-1 cycles, counted 0..LAT-2.
  localparam logic [3:0] LAST_CNT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  stateT      stateR;
  logic       ownerR;
  logic       weR;
  logic [3:0] cntR;
  logic       grantMemS;
  logic       accessEndS;
`ifdef ARB_RR_EN
  logic       lastMemR;
`endif

  // Pick the requester to serve when the arbiter is idle.
  always_comb begin
    grantMemS = 1'b0;
    if (mem_req && if_req) begin
`ifdef ARB_RR_EN
      grantMemS = ~lastMemR;
`else
      grantMemS = 1'b1;
`endif
    end else if (mem_req) begin
      grantMemS = 1'b1;
    end else begin
      grantMemS = 1'b0;
    end
  end

  // Last edge of the memory access: end of ISSUE for LAT=1, else final WAIT count.
  always_comb begin
    accessEndS = 1'b0;
    if (LAT == 1) begin
      accessEndS = (stateR == ISSUE);
    end else begin
      accessEndS = (stateR == WAIT) && (cntR == LAST_CNT);
    end
  end

  // Transaction FSM with registered memory strobes, read data and done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR    <= IDLE;
      ownerR    <= 1'b0;
      weR       <= 1'b0;
      cntR      <= 4'd0;
      rdata     <= 16'h0000;
      ram_addr  <= 16'h0000;
      ram_wdata <= 16'h0000;
      ram_en    <= 1'b0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
`ifdef ARB_RR_EN
      lastMemR  <= 1'b0;
`endif
    end else begin
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (stateR)
        IDLE: begin
          if (if_req || mem_req) begin
            stateR    <= ISSUE;
            ownerR    <= grantMemS;
            weR       <= grantMemS & mem_we;
            ram_addr  <= grantMemS ? mem_addr : if_addr;
            ram_wdata <= grantMemS ? mem_wdata : 16'h0000;
            ram_en    <= 1'b1;
            ram_wr    <= grantMemS & mem_we;
`ifdef ARB_RR_EN
            lastMemR  <= grantMemS;
`endif
          end else begin
            stateR <= IDLE;
          end
        end
        ISSUE, WAIT: begin
          if (stateR == ISSUE) begin
            cntR <= 4'd0;
          end else begin
            cntR <= cntR + 4'd1;
          end
          if (accessEndS) begin
            stateR   <= DONE;
            if (!weR) begin
              rdata <= ram_rdata;
            end
            if_done  <= ~ownerR;
            mem_done <= ownerR;
          end else begin
            stateR <= WAIT;
          end
        end
        DONE: begin
          stateR <= IDLE;
        end
        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a LAT=4 lane and a LAT=1 lane, each with random requesters,
// directed corner cases and a timing-level reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic        own;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wd;
    int          acc;
  } txnT;

  task automatic check16(input string name, input int ln, input int cyc,
                         input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s lane%0d cycle %0d: got 0x%04h, expected 0x%04h", name, ln, cyc, act, exp);
  endtask

  task automatic check1(input string name, input int ln, input int cyc, input logic act, input logic exp);
    check16(name, ln, cyc, {15'd0, act}, {15'd0, exp});
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 0) ? 4 : 1;

    logic        rstN = 1'b1;
    logic        ifReq = 1'b0, memReq = 1'b0, memWe = 1'b0;
    logic [15:0] ifAddr = 16'h0000, memAddr = 16'h0000, memWdata = 16'h0000, ramRdata = 16'h0000;
    logic        ramEn, ramWr, ifDone, memDone, stallIf, stallMem;
    logic [15:0] ramAddr, ramWdata, rdata;
    int          lcyc = 0;
    int          freeAt = 0;
    logic [15:0] lastRd = 16'h0000;
    logic        ifDoneSeen = 1'b0, memDoneSeen = 1'b0;
    logic        fin = 1'b0;
    txnT         sb[$];
    logic [15:0] hist [int];
`ifdef ARB_RR_EN
    logic        lastMem = 1'b0;
`endif

    mem_arbiter #(.LAT(L)) dut (
      .clk(clk), .rst_n(rstN),
      .if_req(ifReq), .if_addr(ifAddr),
      .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .ram_rdata(ramRdata),
      .ram_en(ramEn), .ram_wr(ramWr), .ram_addr(ramAddr), .ram_wdata(ramWdata),
      .rdata(rdata), .if_done(ifDone), .mem_done(memDone),
      .stall_if(stallIf), .stall_mem(stallMem)
    );

    // Reference model: a free arbiter accepts at the sampling edge; busy until done cycle + 1.
    initial begin
      txnT  t;
      logic pickMem;
      forever begin
        @(posedge clk);
        if (rstN && lcyc >= freeAt && (ifReq || memReq)) begin
`ifdef ARB_RR_EN
          pickMem = memReq && !(ifReq && lastMem);
          lastMem = pickMem;
`else
          pickMem = memReq;
`endif
          t.own  = pickMem;
          t.rd   = !(pickMem && memWe);
          t.addr = pickMem ? memAddr : ifAddr;
          t.wd   = memWdata;
          t.acc  = lcyc;
          sb.push_back(t);
          freeAt = lcyc + L + 2;
        end
        lcyc++;
      end
    end

    // Monitor: compares DUT outputs against the front transaction every cycle.
    initial begin
      logic expIf, expMem, expEn;
      txnT  f;
      forever begin
        @(negedge clk);
        if (rstN) begin
          expIf  = 1'b0;
          expMem = 1'b0;
          expEn  = 1'b0;
          if (sb.size() > 0) begin
            f      = sb[0];
            expEn  = (lcyc == f.acc + 1);
            expIf  = (lcyc == f.acc + L + 1) && !f.own;
            expMem = (lcyc == f.acc + L + 1) && f.own;
            if ((lcyc == f.acc + L + 1) && f.rd) lastRd = hist[f.acc + L];
          end
          check1("ram_en", g, lcyc, ramEn, expEn);
          check1("if_done", g, lcyc, ifDone, expIf);
          check1("mem_done", g, lcyc, memDone, expMem);
          check1("done_exclusive", g, lcyc, ifDone & memDone, 1'b0);
          check1("stall_if", g, lcyc, stallIf, ifReq & ~expIf);
          check1("stall_mem", g, lcyc, stallMem, memReq & ~expMem);
          check16("rdata", g, lcyc, rdata, lastRd);
          if (expEn) begin
            check16("ram_addr", g, lcyc, ramAddr, f.addr);
            check1("ram_wr", g, lcyc, ramWr, !f.rd);
            if (!f.rd) check16("ram_wdata", g, lcyc, ramWdata, f.wd);
          end
          if (ifDone) ifDoneSeen = 1'b1;
          if (memDone) memDoneSeen = 1'b1;
          if (sb.size() > 0 && lcyc >= f.acc + L + 1) sb.delete(0);
        end
      end
    end

    task automatic newIf();
      ifReq  = 1'b1;
      ifAddr = 16'($urandom);
    endtask

    task automatic newMem();
      memReq   = 1'b1;
      memWe    = 1'($urandom_range(0, 1));
      memAddr  = 16'($urandom);
      memWdata = 16'($urandom);
    endtask

    // One cycle of requester behaviour: hold until done, then drop or chain a new request.
    task automatic step(input int startPct, input int holdPct);
      @(posedge clk);
      #1;
      ramRdata   = 16'($urandom);
      hist[lcyc] = ramRdata;
      if (ifReq && ifDoneSeen) begin
        ifDoneSeen = 1'b0;
        if (int'($urandom_range(0, 99)) < holdPct) newIf();
        else ifReq = 1'b0;
      end else if (!ifReq) begin
        ifDoneSeen = 1'b0;
        if (int'($urandom_range(0, 99)) < startPct) newIf();
      end
      if (memReq && memDoneSeen) begin
        memDoneSeen = 1'b0;
        if (int'($urandom_range(0, 99)) < holdPct) newMem();
        else memReq = 1'b0;
      end else if (!memReq) begin
        memDoneSeen = 1'b0;
        if (int'($urandom_range(0, 99)) < startPct) newMem();
      end
    endtask

    task automatic drain(input string name);
      for (int i = 0; i < 100 && (ifReq || memReq); i++) step(0, 0);
      check1(name, g, lcyc, ifReq | memReq, 1'b0);
    endtask

    task automatic chkRst();
      check1("rst_ram_en", g, lcyc, ramEn, 1'b0);
      check1("rst_ram_wr", g, lcyc, ramWr, 1'b0);
      check16("rst_ram_addr", g, lcyc, ramAddr, 16'h0000);
      check16("rst_ram_wdata", g, lcyc, ramWdata, 16'h0000);
      check16("rst_rdata", g, lcyc, rdata, 16'h0000);
      check1("rst_if_done", g, lcyc, ifDone, 1'b0);
      check1("rst_mem_done", g, lcyc, memDone, 1'b0);
    endtask

    // Lane stimulus: reset, directed corner cases, then random traffic.
    initial begin
      #1 rstN = 1'b0;
      repeat (3) step(0, 0);
      #1 chkRst();
      rstN = 1'b1;

      ifAddr = 16'h0010;
      ifReq  = 1'b1;
      drain("drain_read");

      memWe    = 1'b1;
      memAddr  = 16'h0100;
      memWdata = 16'hBEEF;
      memReq   = 1'b1;
      drain("drain_write");

      newIf();
      newMem();
      repeat (40) step(0, 100);
      drain("drain_tie");

      ifAddr = 16'h0020;
      ifReq  = 1'b1;
      repeat (3) step(0, 0);
      newMem();
      drain("drain_late_mem");

      // Reset while a fetch is in flight (WAIT for LAT>1, ISSUE for LAT=1).
      ifAddr = 16'h0030;
      ifReq  = 1'b1;
      for (int i = 0; i < 20 && !(sb.size() > 0 && lcyc == sb[0].acc + ((L > 1) ? 2 : 1)); i++)
        step(0, 0);
      check1("reset_in_flight", g, lcyc, (sb.size() > 0) ? 1'b1 : 1'b0, 1'b1);
      #2 rstN = 1'b0;
      sb.delete();
      lastRd      = 16'h0000;
      freeAt      = 0;
      ifDoneSeen  = 1'b0;
      memDoneSeen = 1'b0;
`ifdef ARB_RR_EN
      lastMem     = 1'b0;
`endif
      ifReq  = 1'b0;
      memReq = 1'b0;
      #1 chkRst();
      repeat (L + 3) step(0, 0);
      #1 chkRst();
      rstN   = 1'b1;
      ifAddr = 16'h0040;
      ifReq  = 1'b1;
      drain("drain_after_reset");

      repeat (600) step(30, 40);
      drain("drain_random");
      fin = 1'b1;
    end
  end

  // Wait for both lanes with a cycle bound, then report.
  initial begin
    for (int i = 0; i < 20000 && !(lane[0].fin && lane[1].fin); i++) @(posedge clk);
    check1("finish", 2, 0, lane[0].fin & lane[1].fin, 1'b1);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning memory access latency in cycles (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch read request, held high until if_done.
REQ-005 SHALL have port if_addr, input, 16, fetch address.
REQ-006 SHALL have port mem_req, input, 1, data-stage request, held high until mem_done.
REQ-007 SHALL have port mem_we, input, 1, data-stage write (1) or read (0).
REQ-008 SHALL have port mem_addr, input, 16, data address.
REQ-009 SHALL have port mem_wdata, input, 16, data write value.
REQ-010 SHALL have port ram_rdata, input, 16, memory read data.
REQ-011 SHALL have port ram_en, output, 1, one-cycle memory access strobe.
REQ-012 SHALL have port ram_wr, output, 1, write qualifier for ram_en.
REQ-013 SHALL have port ram_addr, output, 16, latched access address.
REQ-014 SHALL have port ram_wdata, output, 16, latched write data.
REQ-015 SHALL have port rdata, output, 16, registered read result, held between reads.
REQ-016 SHALL have port if_done, output, 1, one-cycle completion pulse for fetch.
REQ-017 SHALL have port mem_done, output, 1, one-cycle completion pulse for data.
REQ-018 SHALL have ports stall_if and stall_mem, output, 1 each, equal to if_req & ~if_done and mem_req & ~mem_done.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE plus a 1-bit owner register (0 = IF, 1 = MEM).
REQ-020 IDLE SHALL sample requests at the clock edge; any request moves to ISSUE and latches owner, address, write data and write flag; no request stays IDLE.
REQ-021 ISSUE SHALL last exactly one cycle with ram_en=1, ram_wr=owner&latched we, then go to WAIT.
REQ-022 WAIT SHALL count LAT-1 cycles (4-bit counter, cleared on ISSUE), capture ram_rdata into rdata at its last edge for reads only, then go to DONE; LAT=1 SHALL skip WAIT and capture at the end of ISSUE.
REQ-023 DONE SHALL last one cycle asserting the owner's done output only, then return to IDLE.
REQ-024 Request sampled in cycle t SHALL yield done in cycle t+LAT+1; writes SHALL leave rdata unchanged.
REQ-025 Requests arriving or dropping outside IDLE SHALL be ignored; an accepted transaction SHALL always complete with its done pulse.
REQ-026 ram_en SHALL be 0 in every state but ISSUE; ram_addr and ram_wdata SHALL hold latched values until the next accept.
REQ-027 if_done and mem_done SHALL never be high in the same cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, owner=0, counter=0, rdata=0, ram_addr=0, ram_wdata=0, ram_en=0, ram_wr=0, if_done=0, mem_done=0, abandoning any in-flight access without a done pulse.
REQ-029 The round-robin last-granted register SHALL reset to IF so that MEM wins the first tie.

Configuration
REQ-030 Macro ARB_RR_EN defined: on simultaneous if_req and mem_req in IDLE, grant the requester not granted most recently.
REQ-031 ARB_RR_EN undefined: mem_req SHALL always win ties (fixed data priority); last-granted register absent.

Verification
REQ-032 LAT=4, if_req=1 addr 0x0010 alone at cycle 0 -> ram_en cycle 1 addr 0x0010, if_done cycle 5, rdata=ram_rdata value of cycle 4.
REQ-033 mem_req=1 mem_we=1 addr 0x0100 wdata 0xBEEF -> ram_en=ram_wr=1 with 0xBEEF, mem_done after LAT+1 cycles, rdata unchanged.
REQ-034 if_req and mem_req both held, no ARB_RR_EN -> grants MEM, MEM, MEM...; with ARB_RR_EN -> MEM, IF, MEM, IF alternating.
REQ-035 mem_req raised during an IF transaction's WAIT -> ignored until IDLE, then granted; stall_mem high throughout.
REQ-036 rst_n pulsed low during WAIT -> all outputs 0 asynchronously, no done pulse, fresh request after release completes normally.
REQ-037 LAT=1 -> ram_en cycle 1, done cycle 2, rdata captured from cycle 1.
